segre_mem_arbiter: RTL and testbench
====================================

// Module: segre_mem_arbiter
// PURPOSE
//   Shares the single main-memory port between the instruction cache (line
//   refills on IF misses) and the data cache (line refills and dirty-line
//   writebacks). Grants one whole-line transaction at a time, drives the memory
//   command, routes the returned line back to the owning cache with a one-cycle
//   ready pulse, and flags memory transactions that exceed a cycle budget.
// PARAMETERS
//   ADDR_SIZE       32   byte-address width
//   LINE_BYTES      16   cache line size in bytes (= CACHE_LINE_SIZE_BYTES)
//   TIMEOUT_CYCLES  255  cycles in a busy state before timeout_o sets (>=1)
// PORTS
//   clk_i       in   1               clock, rising edge
//   rsn_i       in   1               reset, asynchronous, active-low
//   ic_rd_i     in   1               icache line-read request (level, held until ic_ready_o)
//   ic_addr_i   in   ADDR_SIZE       icache request address
//   ic_ready_o  out  1               1-cycle pulse: ic_line_o valid, icache transaction done
//   ic_line_o   out  LINE_BYTES*8    line returned to icache
//   dc_rd_i     in   1               dcache line-read request (level, held until dc_ready_o)
//   dc_wr_i     in   1               dcache writeback request (level, held until dc_ready_o)
//   dc_addr_i   in   ADDR_SIZE       dcache request address
//   dc_line_i   in   LINE_BYTES*8    dcache writeback line
//   dc_ready_o  out  1               1-cycle pulse: dcache transaction done (dc_line_o valid on read)
//   dc_line_o   out  LINE_BYTES*8    line returned to dcache
//   mem_rd_o    out  1               memory read command (level)
//   mem_wr_o    out  1               memory write command (level)
//   mem_addr_o  out  ADDR_SIZE       memory address
//   mem_line_o  out  LINE_BYTES*8    memory write data
//   mem_ready_i in   1               memory completion, 1-cycle pulse
//   mem_line_i  in   LINE_BYTES*8    memory read data, valid with mem_ready_i
//   busy_o      out  1               state != IDLE
//   timeout_o   out  1               sticky: some transaction exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//   - All outputs registered; on reset all outputs 0, state IDLE, rr pointer = IC
//     (so dcache wins the first tie), timeout counter 0. Reset mid-transaction
//     abandons it: no ready pulse is produced.
//   - States: IDLE, BUSY_IC, BUSY_DC, DONE.
//   - IDLE: if any request, pick winner; only one requester -> it wins; both ->
//     the one not granted last (round-robin). dc_wr_i and dc_rd_i both high ->
//     writeback served first. Next state BUSY_IC/BUSY_DC; address/data latched
//     into mem_addr_o/mem_line_o and mem_rd_o or mem_wr_o asserted on that edge.
//   - BUSY_x: command, address, data held stable until mem_ready_i. On the
//     mem_ready_i cycle: next edge drops mem_rd_o/mem_wr_o, pulses x_ready_o,
//     captures mem_line_i into x_line_o (read only), updates rr pointer, -> DONE.
//   - DONE: one cycle, requests ignored (requester drops its level), -> IDLE.
//   - Latency: request sampled at cycle 0 -> command from cycle 1; mem_ready_i at
//     cycle k -> x_ready_o at cycle k+1; new grant earliest sampled at k+2.
//   - x_line_o keeps its last value outside the pulse; non-owner ready stays 0.
//   - mem_ready_i in IDLE or DONE: ignored, no output change.
//   - Timeout: counter increments each BUSY cycle, clears on entering BUSY,
//     saturates; reaching TIMEOUT_CYCLES sets timeout_o (sticky until reset);
//     transaction keeps waiting, no abort.
//   - Requests dropped while granted: transaction still completes and pulses.
// TESTING
//   - IC only, addr 0x100, mem_ready_i at cycle 4 -> mem_rd_o=1 cycles 1..4,
//     mem_addr_o=0x100, ic_ready_o pulse cycle 5 with ic_line_o=mem_line_i.
//   - IC+DC read same cycle after reset -> DC served first, then IC; no overlap,
//     dc_ready_o then ic_ready_o, each exactly one cycle.
//   - Both held continuously for 4 transactions -> grants DC,IC,DC,IC.
//   - dc_wr_i+dc_rd_i, addr 0x2000, line 0xA5.. -> mem_wr_o with mem_line_o=0xA5..,
//     dc_ready_o pulse, then separate read transaction.
//   - TIMEOUT_CYCLES=4, mem_ready_i withheld 10 cycles -> timeout_o=1 after 4th
//     busy cycle, stays 1 after completion; spurious mem_ready_i in IDLE ignored.
//   - rsn_i low during BUSY_DC -> all outputs 0 asynchronously, no dc_ready_o.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: round-robin arbiter giving icache refills and dcache refills/writebacks one whole-line memory transaction at a time
module segre_mem_arbiter #(
  parameter int ADDR_SIZE      = 32,
  parameter int LINE_BYTES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rsn_i,
  input  logic                    ic_rd_i,
  input  logic [ADDR_SIZE-1:0]    ic_addr_i,
  output logic                    ic_ready_o,
  output logic [LINE_BYTES*8-1:0] ic_line_o,
  input  logic                    dc_rd_i,
  input  logic                    dc_wr_i,
  input  logic [ADDR_SIZE-1:0]    dc_addr_i,
  input  logic [LINE_BYTES*8-1:0] dc_line_i,
  output logic                    dc_ready_o,
  output logic [LINE_BYTES*8-1:0] dc_line_o,
  output logic                    mem_rd_o,
  output logic                    mem_wr_o,
  output logic [ADDR_SIZE-1:0]    mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_line_o,
  input  logic                    mem_ready_i,
  input  logic [LINE_BYTES*8-1:0] mem_line_i,
  output logic                    busy_o,
  output logic                    timeout_o
);
  localparam int LW = LINE_BYTES * 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC, DONE} state_t;
  state_t state_q, state_d;
  logic last_dc_q, last_dc_d;
  logic mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0] mem_line_q, mem_line_d, ic_line_q, ic_line_d, dc_line_q, dc_line_d;
  logic ic_ready_q, ic_ready_d, dc_ready_q, dc_ready_d;
  logic busy_q, busy_d, timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dc_req, grant_dc;
  assign dc_req = dc_rd_i | dc_wr_i;
  always_comb begin
    state_d    = state_q;
    last_dc_d  = last_dc_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_line_d = mem_line_q;
    ic_line_d  = ic_line_q;
    dc_line_d  = dc_line_q;
    ic_ready_d = 1'b0;
    dc_ready_d = 1'b0;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    grant_dc   = dc_req && (!ic_rd_i || !last_dc_q);
    case (state_q)
      IDLE: if (ic_rd_i || dc_req) begin
        state_d    = grant_dc ? BUSY_DC : BUSY_IC;
        mem_wr_d   = grant_dc && dc_wr_i;
        mem_rd_d   = !(grant_dc && dc_wr_i);
        mem_addr_d = grant_dc ? dc_addr_i : ic_addr_i;
        mem_line_d = (grant_dc && dc_wr_i) ? dc_line_i : mem_line_q;
        cnt_d      = '0;
      end
      BUSY_IC, BUSY_DC: begin
        cnt_d     = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        timeout_d = timeout_q | (cnt_d == CW'(TIMEOUT_CYCLES));
        if (mem_ready_i) begin
          state_d    = DONE;
          mem_rd_d   = 1'b0;
          mem_wr_d   = 1'b0;
          last_dc_d  = (state_q == BUSY_DC);
          ic_ready_d = (state_q == BUSY_IC);
          dc_ready_d = (state_q == BUSY_DC);
          ic_line_d  = (state_q == BUSY_IC) ? mem_line_i : ic_line_q;
          dc_line_d  = (state_q == BUSY_DC && !mem_wr_q) ? mem_line_i : dc_line_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      last_dc_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_line_q <= '0;
      ic_line_q  <= '0;
      dc_line_q  <= '0;
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dc_q  <= last_dc_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_line_q <= mem_line_d;
      ic_line_q  <= ic_line_d;
      dc_line_q  <= dc_line_d;
      ic_ready_q <= ic_ready_d;
      dc_ready_q <= dc_ready_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end
  assign ic_ready_o = ic_ready_q;
  assign ic_line_o  = ic_line_q;
  assign dc_ready_o = dc_ready_q;
  assign dc_line_o  = dc_line_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_line_o = mem_line_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed and random transactions against a transaction-level arbitration model
module tb_segre_mem_arbiter;
  localparam int TMO = 4;
  logic clk_i = 1'b0, rsn_i = 1'b0;
  logic ic_rd_i = 1'b0, dc_rd_i = 1'b0, dc_wr_i = 1'b0, mem_ready_i = 1'b0;
  logic [31:0] ic_addr_i = '0, dc_addr_i = '0;
  logic [127:0] dc_line_i = '0, mem_line_i = '0;
  logic ic_ready_o, dc_ready_o, mem_rd_o, mem_wr_o, busy_o, timeout_o;
  logic [31:0] mem_addr_o;
  logic [127:0] ic_line_o, dc_line_o, mem_line_o;
  int n_pass = 0, n_tot = 0;
  bit last_dc = 1'b0, exp_tmo = 1'b0;
  logic [127:0] exp_ic_line = '0, exp_dc_line = '0;
  segre_mem_arbiter #(.ADDR_SIZE(32), .LINE_BYTES(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_rd_i(ic_rd_i), .ic_addr_i(ic_addr_i), .ic_ready_o(ic_ready_o), .ic_line_o(ic_line_o),
    .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i), .dc_addr_i(dc_addr_i), .dc_line_i(dc_line_i),
    .dc_ready_o(dc_ready_o), .dc_line_o(dc_line_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_line_o(mem_line_o),
    .mem_ready_i(mem_ready_i), .mem_line_i(mem_line_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic do_reset;
    rsn_i = 1'b0; ic_rd_i = 1'b0; dc_rd_i = 1'b0; dc_wr_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    chk("rst_flags", {ic_ready_o, dc_ready_o, mem_rd_o, mem_wr_o, busy_o, timeout_o}, '0);
    chk("rst_lines", ic_line_o | dc_line_o | mem_line_o, '0);
    chk("rst_addr", mem_addr_o, '0);
    tick;
    rsn_i = 1'b1;
    last_dc = 1'b0; exp_tmo = 1'b0; exp_ic_line = '0; exp_dc_line = '0;
  endtask
  // Called in an IDLE cycle with at least one request driven; runs the winner to completion.
  task automatic run_one(input int lat);
    bit ic, dc, wdc, wr;
    logic [31:0] a;
    logic [127:0] d, r;
    ic = ic_rd_i; dc = dc_rd_i | dc_wr_i;
    wdc = (ic && dc) ? !last_dc : dc;
    wr = wdc && dc_wr_i;
    a = wdc ? dc_addr_i : ic_addr_i;
    d = dc_line_i;
    r = rand128();
    for (int i = 1; i <= lat; i++) begin
      tick;
      chk("mem_rd", mem_rd_o, !wr);
      chk("mem_wr", mem_wr_o, wr);
      chk("mem_addr", mem_addr_o, a);
      if (wr) chk("mem_line", mem_line_o, d);
      chk("busy", busy_o, 1);
      chk("ready_early", {ic_ready_o, dc_ready_o}, 0);
      chk("timeout_busy", timeout_o, exp_tmo);
      if (i >= TMO) exp_tmo = 1'b1;
      if (i == lat) begin mem_ready_i = 1'b1; mem_line_i = r; end
    end
    tick;
    mem_ready_i = 1'b0;
    mem_line_i = rand128();
    if (!wdc) exp_ic_line = r;
    else if (!wr) exp_dc_line = r;
    chk("ic_ready", ic_ready_o, !wdc);
    chk("dc_ready", dc_ready_o, wdc);
    chk("ic_line", ic_line_o, exp_ic_line);
    chk("dc_line", dc_line_o, exp_dc_line);
    chk("cmd_drop", {mem_rd_o, mem_wr_o}, 0);
    chk("timeout_done", timeout_o, exp_tmo);
    last_dc = wdc;
    if (!wdc) ic_rd_i = 1'b0;
    else if (wr) dc_wr_i = 1'b0;
    else dc_rd_i = 1'b0;
    tick;
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", {ic_ready_o, dc_ready_o}, 0);
  endtask
  initial begin
    do_reset;
    ic_addr_i = 32'h100; ic_rd_i = 1'b1;
    run_one(4);
    do_reset;
    ic_addr_i = 32'h300; ic_rd_i = 1'b1;
    dc_addr_i = 32'h400; dc_rd_i = 1'b1;
    run_one(2);
    run_one(3);
    for (int i = 0; i < 4; i++) begin
      ic_rd_i = 1'b1; dc_rd_i = 1'b1;
      run_one(1 + i % 3);
    end
    ic_rd_i = 1'b0; dc_rd_i = 1'b0;
    tick;
    dc_addr_i = 32'h2000; dc_line_i = {16{8'hA5}}; dc_wr_i = 1'b1; dc_rd_i = 1'b1;
    run_one(2);
    run_one(2);
    ic_addr_i = 32'h500; ic_rd_i = 1'b1;
    run_one(10);
    mem_ready_i = 1'b1; mem_line_i = rand128();
    tick;
    mem_ready_i = 1'b0;
    chk("spur_ready", {ic_ready_o, dc_ready_o}, 0);
    chk("spur_lines", {ic_line_o, dc_line_o}, {exp_ic_line, exp_dc_line});
    chk("spur_cmd", {mem_rd_o, mem_wr_o, busy_o}, 0);
    chk("tmo_sticky", timeout_o, 1);
    dc_addr_i = 32'h600; dc_rd_i = 1'b1;
    tick;
    tick;
    chk("pre_rst_busy", busy_o, 1);
    do_reset;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_dc_ready", dc_ready_o, 0);
      chk("post_rst_busy", busy_o, 0);
    end
    for (int n = 0; n < 40; n++) begin
      if (!ic_rd_i && $urandom_range(1) == 1) begin
        ic_rd_i = 1'b1; ic_addr_i = $urandom & ~32'hF;
      end
      if (!dc_rd_i && !dc_wr_i) begin
        int k;
        k = $urandom_range(3);
        dc_addr_i = $urandom & ~32'hF; dc_line_i = rand128();
        dc_rd_i = k[0]; dc_wr_i = k[1];
      end
      if (!ic_rd_i && !dc_rd_i && !dc_wr_i) begin
        ic_rd_i = 1'b1; ic_addr_i = $urandom & ~32'hF;
      end
      run_one($urandom_range(1, 6));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
